// File: rtl/controlpath_pkg.sv
// Shared control-path definitions: sequencer state encodings and instruction width.
package controlpath_pkg;

    localparam logic [3:0] ST_IDLE      = 4'b0000;
    localparam logic [3:0] ST_FETCH     = 4'b0001;
    localparam logic [3:0] ST_DECODE    = 4'b0010;
    localparam logic [3:0] ST_EXECUTE   = 4'b0011;
    localparam logic [3:0] ST_WRITEBACK = 4'b0100;
    localparam logic [3:0] ST_STOPPED   = 4'b1000;

    localparam int INSTR_W = 32;

    typedef enum logic [3:0] {
        IDLE      = ST_IDLE,
        FETCH     = ST_FETCH,
        DECODE    = ST_DECODE,
        EXECUTE   = ST_EXECUTE,
        WRITEBACK = ST_WRITEBACK,
        STOPPED   = ST_STOPPED
    } seq_state_t;

endpackage

// File: rtl/program_counter.sv
// Program counter register: async reset to RESET_PC, advances by PC_STEP when enabled.
module program_counter #(
    parameter int                    PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC = '0,
    parameter logic [PC_WIDTH-1:0]   PC_STEP  = PC_WIDTH'(1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inc_en,
    output logic [PC_WIDTH-1:0] pc
);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;

    // Addition is truncated to PC_WIDTH, so the top of the space wraps to 0.
    always_comb begin
        pc_d = pc_q;
        if (inc_en) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instruction_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer owning the PC and instruction register.
module instruction_sequencer
    import controlpath_pkg::*;
#(
    parameter int                    PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC = '0,
    parameter logic [PC_WIDTH-1:0]   PC_STEP  = PC_WIDTH'(1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                halt_req,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_valid,
    input  logic [31:0]         imem_data,
    output logic [31:0]         instruction,
    input  logic                invalid_instruction,
    input  logic [1:0]          alu_write_mask,
    output logic                alu_start,
    input  logic                alu_done,
    output logic [1:0]          alu_write,
    output logic                pc_inc,
    output logic [PC_WIDTH-1:0] pc,
    output logic                stopped,
    output logic                busy
);

    seq_state_t           state_q;
    seq_state_t           state_d;
    logic [INSTR_W-1:0]   instruction_q;
    logic [INSTR_W-1:0]   instruction_d;
    logic                 halt_pending_q;
    logic                 halt_pending_d;
    logic                 start_q;
    logic                 start_d;

    always_comb begin
        state_d        = state_q;
        instruction_d  = instruction_q;
        halt_pending_d = halt_pending_q | halt_req;
        start_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A halt request in the same cycle as run wins.
                halt_pending_d = 1'b0;
                if (run && !halt_req && !halt_pending_q) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (imem_valid) begin
                    instruction_d = imem_data;
                    state_d       = DECODE;
                end
            end
            DECODE: begin
                if (invalid_instruction) begin
                    state_d = STOPPED;
                end else begin
                    state_d = EXECUTE;
                    start_d = 1'b1;
                end
            end
            EXECUTE: begin
                if (alu_done) begin
                    state_d = WRITEBACK;
                end
            end
            WRITEBACK: begin
                if (halt_pending_q || halt_req) begin
                    state_d        = IDLE;
                    halt_pending_d = 1'b0;
                end else begin
                    state_d = FETCH;
                end
            end
            STOPPED: begin
                halt_pending_d = halt_pending_q;
            end
            default: begin
                state_d        = IDLE;
                halt_pending_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            instruction_q  <= '0;
            halt_pending_q <= 1'b0;
            start_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            instruction_q  <= instruction_d;
            halt_pending_q <= halt_pending_d;
            start_q        <= start_d;
        end
    end

    program_counter #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_program_counter (
        .clk    (clk),
        .reset  (reset),
        .inc_en (state_q == WRITEBACK),
        .pc     (pc)
    );

    // Strobes come from registered state only; start_q marks the first EXECUTE cycle.
    always_comb begin
        imem_req  = (state_q == FETCH);
        alu_start = start_q;
        alu_write = (state_q == WRITEBACK) ? alu_write_mask : 2'b00;
        pc_inc    = (state_q == WRITEBACK);
        stopped   = (state_q == STOPPED);
        busy      = (state_q != IDLE) && (state_q != STOPPED);
    end

    assign imem_addr   = pc;
    assign instruction = instruction_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer, with a small decoder model and a 4-bit PC instance.
module tb_instruction_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run, halt_req, imem_valid, alu_done;
    logic [31:0] imem_data;
    logic        imem_req, alu_start, pc_inc, stopped, busy;
    logic [31:0] imem_addr, pc, instruction;
    logic        invalid_instruction;
    logic [1:0]  alu_write_mask, alu_write;

    logic        run2, imem_valid2, alu_done2;
    logic [31:0] imem_data2;
    logic        imem_req2, alu_start2, pc_inc2, stopped2, busy2;
    logic [3:0]  imem_addr2, pc2;
    logic [31:0] instruction2;
    logic        invalid2;
    logic [1:0]  mask2, alu_write2;

    int n_tests = 0;
    int n_fail  = 0;
    int n_start = 0;
    int n_inc   = 0;
    int n_req   = 0;
    int s0, i0, r0;

    always #5 clk = ~clk;

    assign invalid_instruction = (instruction[31:28] == 4'hF);
    assign alu_write_mask      = instruction[1:0];
    assign invalid2            = (instruction2[31:28] == 4'hF);
    assign mask2               = instruction2[1:0];

    instruction_sequencer #(.PC_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .run(run), .halt_req(halt_req),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
        .imem_data(imem_data), .instruction(instruction),
        .invalid_instruction(invalid_instruction), .alu_write_mask(alu_write_mask),
        .alu_start(alu_start), .alu_done(alu_done), .alu_write(alu_write),
        .pc_inc(pc_inc), .pc(pc), .stopped(stopped), .busy(busy)
    );

    instruction_sequencer #(.PC_WIDTH(4), .RESET_PC(4'd15), .PC_STEP(4'd1)) dut2 (
        .clk(clk), .reset(reset), .run(run2), .halt_req(1'b0),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_valid(imem_valid2),
        .imem_data(imem_data2), .instruction(instruction2),
        .invalid_instruction(invalid2), .alu_write_mask(mask2),
        .alu_start(alu_start2), .alu_done(alu_done2), .alu_write(alu_write2),
        .pc_inc(pc_inc2), .pc(pc2), .stopped(stopped2), .busy(busy2)
    );

    always @(negedge clk) begin
        if (alu_start) n_start++;
        if (pc_inc)    n_inc++;
        if (imem_req)  n_req++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one valid instruction starting from the first FETCH cycle, ending in the next state.
    task automatic exec_instr(input logic [31:0] data);
        imem_valid = 1'b1; imem_data = data;
        tick();
        imem_valid = 1'b0;
        tick();
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; run = 0; halt_req = 0; imem_valid = 0; alu_done = 0; imem_data = 0;
        run2 = 0; imem_valid2 = 0; alu_done2 = 0; imem_data2 = 0;
        tick(); tick();
        reset = 1'b0;
        tick();

        check("rst_imem_req", imem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_pc", pc, 0);
        check("rst_instr", instruction, 0);
        check("rst_stopped", stopped, 0);
        check("rst_strobes", {alu_start, pc_inc, alu_write}, 0);
        check("rst_pc2", pc2, 15);

        // Basic instruction with zero-wait fetch and ALU.
        run = 1'b1;
        tick();
        run = 1'b0;
        check("t1_fetch_req", imem_req, 1);
        check("t1_fetch_addr", imem_addr, 0);
        imem_valid = 1'b1; imem_data = 32'h0000_0001;
        tick();
        imem_valid = 1'b0;
        check("t1_decode_instr", instruction, 32'h1);
        check("t1_decode_req", imem_req, 0);
        check("t1_decode_start", alu_start, 0);
        tick();
        check("t1_exec_start", alu_start, 1);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        check("t1_wb_write", alu_write, 2'b01);
        check("t1_wb_pcinc", pc_inc, 1);
        check("t1_wb_pc", pc, 0);
        tick();
        check("t1_next_pc", pc, 1);
        check("t1_next_addr", imem_addr, 1);
        check("t1_next_req", imem_req, 1);
        check("t1_next_pcinc", pc_inc, 0);

        // Delayed fetch (5 cycles) and delayed done (3 cycles).
        r0 = n_req;
        repeat (5) tick();
        check("t2_addr_stable", imem_addr, 1);
        imem_valid = 1'b1; imem_data = 32'h0000_0002;
        tick();
        imem_valid = 1'b0;
        check("t2_req_cycles", n_req - r0, 6);
        s0 = n_start; i0 = n_inc;
        tick();
        check("t2_start", alu_start, 1);
        tick();
        check("t2_start_once", alu_start, 0);
        check("t2_exec_busy", busy, 1);
        tick(); tick();
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        check("t2_wb_write", alu_write, 2'b10);
        tick();
        check("t2_start_count", n_start - s0, 1);
        check("t2_inc_count", n_inc - i0, 1);
        check("t2_pc", pc, 2);

        // Advance to pc=7, then an invalid instruction.
        repeat (5) exec_instr(32'h0000_0000);
        check("t3_pc_before", pc, 7);
        imem_valid = 1'b1; imem_data = 32'hF000_0000;
        tick();
        imem_valid = 1'b0;
        check("t3_decode_instr", instruction, 32'hF000_0000);
        s0 = n_start; i0 = n_inc;
        tick();
        check("t3_stopped", stopped, 1);
        check("t3_busy", busy, 0);
        check("t3_pc", pc, 7);
        for (int k = 0; k < 4; k++) begin
            run = k[0]; alu_done = 1'b1;
            tick();
            check("t3_still_stopped", stopped, 1);
            check("t3_no_req", imem_req, 0);
            check("t3_no_write", alu_write, 0);
        end
        run = 1'b0; alu_done = 1'b0;
        check("t3_no_start", n_start - s0, 0);
        check("t3_no_inc", n_inc - i0, 0);
        check("t3_pc_frozen", pc, 7);
        reset = 1'b1;
        #1;
        check("t3_rst_stopped", stopped, 0);
        check("t3_rst_pc", pc, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        tick();
        check("t3_idle_busy", busy, 0);

        // Halt during EXECUTE retires the instruction, then IDLE.
        run = 1'b1;
        tick();
        run = 1'b0;
        imem_valid = 1'b1; imem_data = 32'h0000_0003;
        tick();
        imem_valid = 1'b0;
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        check("t4_wb_pcinc", pc_inc, 1);
        check("t4_wb_write", alu_write, 2'b11);
        tick();
        check("t4_idle_busy", busy, 0);
        check("t4_idle_req", imem_req, 0);
        check("t4_pc", pc, 1);
        run = 1'b1; halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("t4_runhalt_busy", busy, 0);
        check("t4_runhalt_req", imem_req, 0);
        tick();
        run = 1'b0;
        check("t4_run_after", imem_req, 1);

        // Reset mid-FETCH, then stale valid after release.
        reset = 1'b1;
        #1;
        check("t6_req_drop", imem_req, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        imem_valid = 1'b1; imem_data = 32'h0000_ABCD;
        tick();
        check("t6_stale_instr", instruction, 0);
        check("t6_stale_busy", busy, 0);
        imem_valid = 1'b0;

        // Reset mid-EXECUTE, then stale done after release.
        run = 1'b1;
        tick();
        run = 1'b0;
        imem_valid = 1'b1; imem_data = 32'h0000_0001;
        tick();
        imem_valid = 1'b0;
        tick();
        check("t6_exec_start", alu_start, 1);
        reset = 1'b1;
        #1;
        check("t6_start_drop", alu_start, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        check("t6_done_ignored", {busy, pc_inc}, 0);

        // 4-bit PC starting at 15 wraps to 0 on the first retire.
        run2 = 1'b1;
        tick();
        run2 = 1'b0;
        check("t5_addr", imem_addr2, 15);
        check("t5_req", imem_req2, 1);
        imem_valid2 = 1'b1; imem_data2 = 32'h0000_0001;
        tick();
        imem_valid2 = 1'b0;
        tick();
        check("t5_start", alu_start2, 1);
        alu_done2 = 1'b1;
        tick();
        alu_done2 = 1'b0;
        check("t5_wb_pcinc", pc_inc2, 1);
        check("t5_wb_pc", pc2, 15);
        check("t5_wb_write", alu_write2, 2'b01);
        tick();
        check("t5_wrap_pc", pc2, 0);
        check("t5_wrap_addr", imem_addr2, 0);
        check("t5_state", {stopped2, busy2, instruction2[0]}, 3'b011);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
